// File: rtl/parity_pkg.sv
// ---------------------------------------------------------------------------
// parity_pkg
// Shared constants and helpers for the parity encoder / checker pair.
// Even parity: an encoded word {parity, payload} is good when the XOR over
// all ENC_W bits is zero.
//   PAY_W        payload width
//   ENC_W        encoded word width (payload + one parity bit)
//   PAR_BIT      bit position of the parity bit inside an encoded word
//   calc_parity  even-parity bit for a payload
// ---------------------------------------------------------------------------
package parity_pkg;

  localparam int PAY_W   = 8;
  localparam int ENC_W   = PAY_W + 1;
  localparam int PAR_BIT = PAY_W;

  function automatic logic calc_parity(input logic [PAY_W-1:0] payload);
    return ^payload;
  endfunction

endpackage

// File: rtl/parity_fifo.sv
// ---------------------------------------------------------------------------
// parity_fifo
// Single-clock synchronous FIFO with a registered occupancy count.
// The head entry is presented combinationally at rdata and reads as zero
// while the FIFO is empty.
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset (pointers and count only)
//   push   write wdata (ignored when full)
//   wdata  entry to write
//   pop    advance the read pointer (ignored when empty)
//   rdata  entry at the read pointer, zero when empty
//   full   DEPTH entries held
//   empty  no entries held
// ---------------------------------------------------------------------------
module parity_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // NOTE: storage has no reset; entries are only ever read after being
  // written because rdata is masked while the count says empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/parity_check_rx.sv
// ---------------------------------------------------------------------------
// parity_check_rx
// Receive side of the parity link: checks even parity on each 9-bit word,
// strips the parity bit and queues {err, payload} in a small FIFO. A
// saturating counter tracks how many accepted words failed the check.
// Build option:
//   PARITY_DROP_ERR_EN  errored words are counted but never enter the FIFO,
//                       so out_err always reads 0.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   in_valid    encoded word present
//   in_data     {parity, payload[7:0]}
//   in_ready    word accepted this cycle when in_valid is high (= !full)
//   out_valid   FIFO head valid
//   out_data    payload at FIFO head
//   out_err     parity error flag of FIFO head
//   out_ready   consumer takes the head word
//   err_clr     clear err_count (applied before this cycle's increment)
//   err_count   saturating count of errored words accepted
// ---------------------------------------------------------------------------
module parity_check_rx
  import parity_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [ENC_W-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [PAY_W-1:0] out_data,
  output logic             out_err,
  input  logic             out_ready,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_count
);

  logic             word_err;
  logic             accept;
  logic             fifo_push;
  logic             full;
  logic             empty;
  logic [PAY_W:0]   head;

  assign word_err = calc_parity(in_data[PAY_W-1:0]) ^ in_data[PAR_BIT];

  // Held low during reset so a word presented in the reset cycle is not
  // consumed by the upstream handshake.
  assign in_ready = !rst && !full;
  assign accept   = in_valid && in_ready;

`ifdef PARITY_DROP_ERR_EN
  // Errored words are still consumed (accept) but never stored, so every
  // stored err bit is 0 and out_err stays low.
  assign fifo_push = accept && !word_err;
`else
  assign fifo_push = accept;
`endif

  parity_fifo #(
    .DEPTH (DEPTH),
    .W     (PAY_W + 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({word_err, in_data[PAY_W-1:0]}),
    .pop   (out_ready),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;
  assign out_data  = head[PAY_W-1:0];
  assign out_err   = head[PAY_W];

  // Clear wins over the old value, but an errored word in the same cycle
  // still counts, leaving 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= (accept && word_err) ? CNT_W'(1) : '0;
    end else if (accept && word_err && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_parity_check_rx.sv
// ---------------------------------------------------------------------------
// tb_parity_check_rx
// Directed bench for parity_check_rx with DEPTH = 4 and a 4-bit error
// counter so saturation is reachable in a few cycles. Inputs change and
// outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_parity_check_rx;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
`ifdef PARITY_DROP_ERR_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [8:0]       in_data;
  logic             in_ready;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_err;
  logic             out_ready;
  logic             err_clr;
  logic [CNT_W-1:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  parity_check_rx #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_ready (out_ready),
    .err_clr   (err_clr),
    .err_count (err_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [8:0] w);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
  endtask

  logic [8:0]       fill_words [4];
  logic [7:0]       fill_pay   [4];
  logic [CNT_W-1:0] exp_cnt;

  initial begin
    fill_words = '{9'h000, 9'h101, 9'h003, 9'h1A8};
    fill_pay   = '{8'h00, 8'h01, 8'h03, 8'hA8};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; err_clr = 1'b0;
    tick();
    tick();
    check("rst_in_ready",  in_ready,  0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data,  0);
    check("rst_out_err",   out_err,   0);
    check("rst_err_count", err_count, 0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", in_ready, 1);

    // Good words back-to-back with the consumer always ready.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 9'h0EE;
    tick();
    check("good0_valid", out_valid, 1);
    check("good0_data",  out_data,  8'hEE);
    check("good0_err",   out_err,   0);
    in_data = 9'h1F8;
    tick();
    check("good1_valid", out_valid, 1);
    check("good1_data",  out_data,  8'hF8);
    check("good1_err",   out_err,   0);
    in_valid = 1'b0;
    tick();
    check("good_drained", out_valid, 0);
    check("good_cnt",     err_count, 0);

    // Single errored word.
    out_ready = 1'b0;
    push_word(9'h0F8);
    check("err_valid", out_valid, DROP ? 0 : 1);
    check("err_data",  out_data,  DROP ? 8'h00 : 8'hF8);
    check("err_flag",  out_err,   DROP ? 0 : 1);
    check("err_cnt",   err_count, 1);
    out_ready = 1'b1;
    tick();
    check("err_drained", out_valid, 0);

    // Fill to DEPTH with backpressure, then drain.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      push_word(fill_words[i]);
      check($sformatf("fill%0d_in_ready", i), in_ready, (i == DEPTH - 1) ? 0 : 1);
    end
    in_valid = 1'b1;
    in_data  = 9'h055;
    tick();
    in_valid = 1'b0;
    check("full_hold_ready", in_ready, 0);
    check("full_hold_head",  out_data, 8'h00);
    out_ready = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      tick();
      if (i == 1) check("drain_ready_back", in_ready, 1);
      check($sformatf("drain%0d_data", i), out_data, fill_pay[i]);
      check($sformatf("drain%0d_valid", i), out_valid, 1);
    end
    tick();
    check("drain_empty", out_valid, 0);
    check("drain_cnt",   err_count, 1);

    // Simultaneous push and pop at occupancy 2.
    out_ready = 1'b0;
    push_word(9'h011);
    push_word(9'h022);
    out_ready = 1'b1;
    push_word(9'h107);
    out_ready = 1'b0;
    check("pp_head0", out_data, 8'h22);
    out_ready = 1'b1;
    tick();
    check("pp_head1", out_data,  8'h07);
    check("pp_valid", out_valid, 1);
    tick();
    check("pp_empty", out_valid, 0);

    // Saturating counter.
    exp_cnt   = 1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 9'h0F8;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
      check($sformatf("sat%0d_cnt", i), err_count, exp_cnt);
    end
    check("sat_final", err_count, 4'hF);
    err_clr = 1'b1;
    tick();
    check("clr_with_err", err_count, 1);
    in_valid = 1'b0;
    tick();
    check("clr_alone", err_count, 0);
    err_clr = 1'b0;
    tick();
    check("sat_drained", out_valid, 0);

    // Reset mid-operation with a push presented in the reset cycle.
    out_ready = 1'b0;
    push_word(9'h0EE);
    push_word(9'h1F8);
    push_word(9'h0F8);
    check("pre_rst_cnt",  err_count, 1);
    check("pre_rst_head", out_data,  8'hEE);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 9'h055;
    #1;
    check("in_rst_ready", in_ready, 0);
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("post_rst_valid", out_valid, 0);
    check("post_rst_data",  out_data,  0);
    check("post_rst_cnt",   err_count, 0);
    check("post_rst_ready", in_ready,  1);
    out_ready = 1'b1;
    tick();
    check("post_rst_stale", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
